// File: rtl/chacha_pkg.sv
// Shared ChaCha20 types: block-function word, output matrix, occupancy encoding.
package chacha_pkg;

   localparam int unsigned WORD_BITS       = 32;
   localparam int unsigned WORDS_PER_BLOCK = 16;
   localparam int unsigned IDX_W           = 4;

   typedef logic [WORD_BITS-1:0] word_t;
   typedef word_t [3:0][3:0]     matrix_t;

   typedef enum logic [1:0] {
      OCC_EMPTY   = 2'd0,
      OCC_PARTIAL = 2'd1,
      OCC_FULL    = 2'd2
   } occ_e;

endpackage

// File: rtl/keystream_slot_store.sv
// Two 16-word matrix slots: whole-matrix write port, single-word read port.
module keystream_slot_store
   import chacha_pkg::*;
#(
   parameter int unsigned WORD_W = 32
) (
   input  logic              clk,
   input  logic              i_wr_en,
   input  logic              i_wr_slot,
   input  matrix_t           i_wr_data,
   input  logic              i_rd_slot,
   input  logic [IDX_W-1:0]  i_rd_idx,
   output logic [WORD_W-1:0] o_rd_data
);

   matrix_t r_slot [2];
   matrix_t w_rd_matrix;

   // Contents are don't-care after reset; occupancy tracking guards reads.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_slot[i_wr_slot] <= i_wr_data;
      end
   end

   // Word i sits at row i/4, column i%4.
   always_comb begin
      w_rd_matrix = r_slot[i_rd_slot];
      o_rd_data   = WORD_W'(w_rd_matrix[i_rd_idx[3:2]][i_rd_idx[1:0]]);
   end

endmodule

// File: rtl/keystream_serializer.sv
// Double-buffered serializer: accepts ChaCha20 output matrices and streams
// them as 16 keystream words each over valid/ready.
module keystream_serializer
   import chacha_pkg::*;
#(
   parameter int unsigned WORD_W = 32,
   parameter int unsigned CNT_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  matrix_t           matrix_in,
   input  logic              load_en,
   output logic              load_ready,
   output logic [WORD_W-1:0] ks_data,
   output logic              ks_valid,
   input  logic              ks_ready,
   output logic              ks_last,
   output logic [IDX_W-1:0]  ks_word_idx,
   output logic [CNT_W-1:0]  blocks_sent,
   output logic              overflow
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);

   occ_e              r_state;
   occ_e              w_state_nxt;
   logic              r_wr_ptr;
   logic              r_rd_ptr;
   logic [IDX_W-1:0]  r_idx;
   logic [CNT_W-1:0]  r_blocks;
   logic              r_overflow;

   logic              w_load_ready;
   logic              w_valid;
   logic              w_load_acc;
   logic              w_hs;
   logic              w_done;
   logic [WORD_W-1:0] w_rd_data;

   assign w_load_acc = load_en && w_load_ready;
   assign w_hs       = w_valid && ks_ready;
   assign w_done     = w_hs && (r_idx == LAST_IDX);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= OCC_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         OCC_EMPTY: begin
            if (w_load_acc) w_state_nxt = OCC_PARTIAL;
         end
         OCC_PARTIAL: begin
            if (w_load_acc && !w_done)      w_state_nxt = OCC_FULL;
            else if (!w_load_acc && w_done) w_state_nxt = OCC_EMPTY;
         end
         OCC_FULL: begin
            if (w_done) w_state_nxt = OCC_PARTIAL;
         end
         default: w_state_nxt = OCC_EMPTY;
      endcase
   end

   // Decoded from registered occupancy only, so no input reaches an output.
   always_comb begin
      w_load_ready = 1'b1;
      w_valid      = 1'b0;
      case (r_state)
         OCC_EMPTY:   begin w_load_ready = 1'b1; w_valid = 1'b0; end
         OCC_PARTIAL: begin w_load_ready = 1'b1; w_valid = 1'b1; end
         OCC_FULL:    begin w_load_ready = 1'b0; w_valid = 1'b1; end
         default:     begin w_load_ready = 1'b1; w_valid = 1'b0; end
      endcase
   end

   // Pointers, word index, drained-block count and sticky overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr   <= 1'b0;
         r_rd_ptr   <= 1'b0;
         r_idx      <= '0;
         r_blocks   <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_load_acc) r_wr_ptr <= ~r_wr_ptr;
         if (w_hs)       r_idx    <= r_idx + IDX_W'(1);
         if (w_done) begin
            r_rd_ptr <= ~r_rd_ptr;
            r_blocks <= r_blocks + CNT_W'(1);
         end
         if (load_en && !w_load_ready) r_overflow <= 1'b1;
      end
   end

   keystream_slot_store #(
      .WORD_W (WORD_W)
   ) u_store (
      .clk       (clk),
      .i_wr_en   (w_load_acc),
      .i_wr_slot (r_wr_ptr),
      .i_wr_data (matrix_in),
      .i_rd_slot (r_rd_ptr),
      .i_rd_idx  (r_idx),
      .o_rd_data (w_rd_data)
   );

   assign load_ready  = w_load_ready;
   assign ks_valid    = w_valid;
   assign ks_data     = w_valid ? w_rd_data : '0;
   assign ks_last     = w_valid && (r_idx == LAST_IDX);
   assign ks_word_idx = r_idx;
   assign blocks_sent = r_blocks;
   assign overflow    = r_overflow;

endmodule

// File: doc/keystream_serializer.md
# keystream_serializer

Receives complete 4x4 ChaCha20 output matrices from the block function and streams them out as 32-bit keystream words over a valid/ready interface for the XOR/AEAD datapath. It is the consuming end of the block function's matrix + serial-enable interface. A two-slot buffer lets the block function compute block N+1 while block N drains. Backpressure returns to the block function through `load_ready`.

## Interface

- `WORD_W`, default 32: keystream word width; must equal `word_t` width.
- `CNT_W`, default 4: width of `blocks_sent`; matches the block function's block counter width.

- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `matrix_in` in 16xWORD_W (`word_t [3:0][3:0]`): block function output matrix, `matrix_in[r][c]`.
- `load_en` in 1: one-cycle strobe; `matrix_in` is valid (block function `serial_enable`).
- `load_ready` out 1: a free slot exists; the load is accepted this cycle.
- `ks_data` out WORD_W: current keystream word.
- `ks_valid` out 1: `ks_data` is valid.
- `ks_ready` in 1: the consumer accepts the word.
- `ks_last` out 1: the current word is word 15 of its block.
- `ks_word_idx` out 4: index (0..15) of the current word.
- `blocks_sent` out CNT_W: count of fully drained blocks; wraps modulo 2^CNT_W.
- `overflow` out 1: sticky; set when a `load_en` is dropped.

## Operation

- **Word order:** word index i = 4*r + c, emitted i = 0..15, i.e. `matrix_in[0][0]` first and `matrix_in[3][3]` last. Word contents pass through unchanged; byte ordering is the consumer's responsibility.
- **Storage:** two slots of 16 words. State: `wr_ptr`, `rd_ptr` (1 bit each), `occ` (0..2), `idx` (4 bits).
- **Occupancy FSM:**
  - EMPTY (occ=0): `load_en` → PARTIAL.
  - PARTIAL (occ=1): `load_en` without block completion → FULL; block completion without `load_en` → EMPTY; both together → PARTIAL.
  - FULL (occ=2): block completion → PARTIAL; any `load_en` is dropped.
- **Load:** `load_ready` = (occ < 2), decoded from registered `occ` only. A load in FULL is dropped even if the last word pops in the same cycle, and `overflow` is set until reset.
- **Accepted load:** `matrix_in` is written into slot `wr_ptr`, then `wr_ptr` toggles.
- **Output:**
  - `ks_valid` = (occ != 0).
  - `ks_data` = slot[`rd_ptr`][`idx`] when valid, else 0.
  - `ks_last` = `ks_valid` && (`idx` == 15).
  - `ks_word_idx` = `idx`.
- **Handshake** (`ks_valid` && `ks_ready`): `idx` increments. At `idx` = 15, `idx` wraps to 0, `rd_ptr` toggles, `occ` decrements, and `blocks_sent` increments.
- **Stability:** while `ks_valid` && !`ks_ready`, `ks_data`, `ks_last` and `ks_word_idx` hold. `ks_valid` never drops without a handshake, except on reset.
- **Slot isolation:** a load never overwrites the slot being read; guaranteed by `occ` < 2.
- **Reset mid-block:** the partial block is discarded and both slots are treated as empty. Slot contents need no reset.

## Timing

- **Reset values:** `ks_valid` 0, `ks_data` 0, `ks_last` 0, `ks_word_idx` 0, `blocks_sent` 0, `overflow` 0, `load_ready` 1.
- **Load-to-output latency:** a load accepted at edge N gives `ks_valid` = 1 with word 0 after edge N (one cycle).
- **Throughput:** one word per cycle with `ks_ready` held high. A queued second block follows word 15 of the first with no bubble.
- **Cycle timing of outputs:** `load_ready` rises the cycle after the completing handshake. `overflow` is set the cycle after the dropped strobe.
- **No combinational paths** from `ks_ready` or `load_en` to any output.
- **Back-to-back loads:** `load_en` on consecutive cycles is legal; the second load is accepted only if occ < 2 at that edge.

## Structure

- **Shared package `chacha_pkg`:**
  - `word_t` (logic [31:0]).
  - `matrix_t` (`word_t [3:0][3:0]`).
  - `WORDS_PER_BLOCK` = 16.
- **Sub-module `keystream_slot_store`:** 2x16xWORD_W register storage. Write port: slot select plus full matrix. Read port: slot select plus word index.
- **Top-level contents:** the occupancy FSM, pointers, counters and handshake logic.

## Test plan

- **Reset:** assert `rst` with `load_en` = 1 → all outputs at their reset values; `load_ready` = 1 after release.
- **Single block:** `matrix_in[r][c]` = 32'h1000_0000 + 4r + c, one `load_en`, `ks_ready` = 1 → words 0x1000_0000..0x1000_000F on 16 consecutive cycles starting the cycle after the load; `ks_last` only on 0x1000_000F; `blocks_sent` = 1.
- **Backpressure:** same matrix with `ks_ready` toggling every cycle → identical 16-word sequence with no duplicates or skips; `ks_data` stable while stalled.
- **Overflow:** `ks_ready` = 0; load A (0xA…), load B (0xB…), load C → `load_ready` = 0 after B, C dropped, `overflow` = 1; then `ks_ready` = 1 → 16 A words then 16 B words, no gap; `blocks_sent` = 2.
- **Simultaneous events:** occ = 1, `load_en` in the same cycle as the handshake on word 15 → occ stays 1, next block's word 0 appears the following cycle, `load_ready` stays 1.
- **Reset mid-block and wrap:**
  - `rst` during word 7 → `ks_valid` = 0 next cycle and `idx` = 0; the next load restarts at word 0.
  - 16 full blocks → `blocks_sent` wraps to 0.
